// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter sharing one 4:1 data mux among four valid/ready
// requesters, feeding a one-entry registered output stage with backpressure.
module rr_mux_arbiter_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_src,
  input  logic         out_ready
);

  logic [1:0]   ptr_q, ptr_d;
  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   src_q, src_d;

  logic         load_en;
  logic         any_req;
  logic         xfer;
  logic [1:0]   win;
  logic [1:0]   idx;
  logic [W-1:0] sel_data;

  assign load_en = !vld_q || out_ready;
  assign any_req = |in_valid;
  assign xfer    = load_en && any_req;

  // Highest offset first so the closest index to ptr overwrites last.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) win = idx;
    end
  end

  always_comb begin
    sel_data = in_data0;
    unique case (win)
      2'd0: sel_data = in_data0;
      2'd1: sel_data = in_data1;
      2'd2: sel_data = in_data2;
      2'd3: sel_data = in_data3;
    endcase
  end

  assign in_ready = xfer ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    ptr_d  = ptr_q;
    vld_d  = vld_q;
    data_d = data_q;
    src_d  = src_q;
    if (xfer) begin
      vld_d  = 1'b1;
      data_d = sel_data;
      src_d  = win;
      ptr_d  = win + 2'd1;
    end else if (load_en) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= 2'd0;
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= 2'd0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Randomised and directed bench for rr_mux_arbiter_4 against a
// behavioural round-robin model.
module tb_rr_mux_arbiter_4;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  int checks;
  int errors;

  int           m_ptr;
  logic         m_ov;
  logic [W-1:0] m_od;
  int           m_os;

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data0(d0), .in_data1(d1), .in_data2(d2), .in_data3(d3),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [W-1:0] pick(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  // Compare DUT with model, advance one clock, update model.
  task automatic step();
    int w;
    bit can_load;
    logic [3:0] er;
    #1;
    can_load = !m_ov || out_ready;
    w = model_winner();
    er = (can_load && w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("in_ready", int'(in_ready), int'(er));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("out_data", int'(out_data), int'(m_od));
    chk("out_src", int'(out_src), m_os);
    @(posedge clk);
    if (can_load) begin
      if (w >= 0) begin
        m_ov = 1'b1;
        m_od = pick(w);
        m_os = w;
        m_ptr = (w + 1) % 4;
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = 0;
  endtask

  initial begin
    logic [W-1:0] lit [4];
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0;
    in_valid = 4'b0000;
    out_ready = 1'b1;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    lit[0] = 4'hA; lit[1] = 4'hB; lit[2] = 4'hC; lit[3] = 4'hD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_src", int'(out_src), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fair rotation
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rot_ready", int'(in_ready), 1 << (i % 4));
      #(-0);
      step();
      chk("rot_src", int'(out_src), i % 4);
      chk("rot_data", int'(out_data), int'(lit[i % 4]));
    end

    // Grant 1 (B), then backpressure
    step();
    chk("bp_src_B", int'(out_src), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_data", int'(out_data), 4'hB);
      chk("bp_src", int'(out_src), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", int'(in_ready), 4'b0100);
    step();

    // Wrap-around from ptr=3
    in_valid = 4'b1001;
    step();
    chk("wrap_src3", int'(out_src), 3);
    step();
    chk("wrap_src0", int'(out_src), 0);
    in_valid = 4'b0010;
    #1;
    chk("wrap_ptr1", int'(in_ready), 4'b0010);
    in_valid = 4'b0000;
    step();

    // Single requester
    in_valid = 4'b0100;
    d2 = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("single_ready", int'(in_ready), 4'b0100);
      step();
      chk("single_data", int'(out_data), 5);
    end
    in_valid = 4'b0000;
    chk("single_vld", int'(out_valid), 1);
    step();
    chk("idle_vld", int'(out_valid), 0);

    // Drain/refill with no bubble
    in_valid = 4'b0010;
    d1 = 4'h3;
    step();
    d1 = 4'h9;
    step();
    chk("refill_vld", int'(out_valid), 1);
    chk("refill_data", int'(out_data), 9);

    // Asynchronous reset mid-burst
    in_valid = 4'b1111;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_src", int'(out_src), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_first", int'(in_ready), 4'b0001);
    step();
    chk("arst_src0", int'(out_src), 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 4'($urandom_range(0, 15));
      d0 = 4'($urandom); d1 = 4'($urandom);
      d2 = 4'($urandom); d3 = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
